// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//   Multi-port register file for the pipelined datapath. It has NUM_RD packed
//   combinational read ports and two write ports; write port 1 wins on an
//   address collision. Write-to-read bypass is optional, and register 0 can be
//   hardwired to zero. A per-register busy scoreboard is set by reserve
//   (issue) and cleared by write (writeback). Decode uses it for hazard
//   detection.
//
// Ports
//   clk         rising-edge clock
//   rstd        synchronous active-low reset, sampled at posedge clk
//   rd_addr     NUM_RD packed read addresses, port 0 in the LSBs
//   rd_data     NUM_RD packed read data, combinational
//   rd_busy     per-port busy flag of the addressed register
//   wr_en0/wr_addr0/wr_data0   write port 0
//   wr_en1/wr_addr1/wr_data1   write port 1 (higher priority)
//   rsv_en/rsv_addr            reserve request (mark register busy)
//   busy_count  registered number of busy registers
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_count
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic              HAS_ZERO  = (ZERO_REG != 0);
    localparam logic              HAS_BYP   = (BYPASS != 0);

    // Population count of the busy vector. DEPTH fits in ADDR_W+1 bits.
    function automatic logic [ADDR_W:0] f_popcount(input logic [DEPTH-1:0] bits);
        logic [ADDR_W:0] sum;
        sum = {(ADDR_W+1){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            sum = sum + {{ADDR_W{1'b0}}, bits[k]};
        end
        return sum;
    endfunction

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_busy;
    logic [ADDR_W:0]          r_busy_count;

    logic                     w_we0;
    logic                     w_we1;
    logic                     w_rsv;
    logic [DEPTH-1:0]         w_busy_nxt;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_busy;

    // Effective enables. With a hardwired zero register, accesses to address 0 are dropped here.
    assign w_we0 = wr_en0 && !(HAS_ZERO && (wr_addr0 == ZERO_ADDR));
    assign w_we1 = wr_en1 && !(HAS_ZERO && (wr_addr1 == ZERO_ADDR));
    assign w_rsv = rsv_en && !(HAS_ZERO && (rsv_addr == ZERO_ADDR));

    // Next busy vector: a write clears the bit and a reserve sets it. The reserve
    // names the newer producer, so it wins over a same-cycle write.
    always_comb begin
        w_busy_nxt = {DEPTH{1'b0}};
        for (int r = 0; r < DEPTH; r++) begin
            w_busy_nxt[r] = (w_rsv && (rsv_addr == ADDR_W'(r)))
                          | (r_busy[r]
                             & ~((w_we0 && (wr_addr0 == ADDR_W'(r)))
                               | (w_we1 && (wr_addr1 == ADDR_W'(r)))));
        end
    end

    // Storage, scoreboard and busy counter. Port 1 is assigned last, so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rstd) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= {DATA_W{1'b0}};
            end
            r_busy       <= {DEPTH{1'b0}};
            r_busy_count <= {(ADDR_W+1){1'b0}};
        end else begin
            if (w_we0) begin
                r_mem[wr_addr0] <= wr_data0;
            end
            if (w_we1) begin
                r_mem[wr_addr1] <= wr_data1;
            end
            r_busy       <= w_busy_nxt;
            r_busy_count <= f_popcount(w_busy_nxt);
        end
    end

    // Read ports. Zero register first, then the optional bypass (port 1 before port 0),
    // then the stored state. A same-cycle reserve is deliberately not bypassed.
    always_comb begin
        logic [ADDR_W-1:0] v_addr;
        w_rd_data = {(NUM_RD*DATA_W){1'b0}};
        w_rd_busy = {NUM_RD{1'b0}};
        v_addr    = ZERO_ADDR;
        for (int i = 0; i < NUM_RD; i++) begin
            v_addr = rd_addr[i*ADDR_W +: ADDR_W];
            if (HAS_ZERO && (v_addr == ZERO_ADDR)) begin
                w_rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                w_rd_busy[i]                  = 1'b0;
            end else if (HAS_BYP && w_we1 && (wr_addr1 == v_addr)) begin
                w_rd_data[i*DATA_W +: DATA_W] = wr_data1;
                w_rd_busy[i]                  = 1'b0;
            end else if (HAS_BYP && w_we0 && (wr_addr0 == v_addr)) begin
                w_rd_data[i*DATA_W +: DATA_W] = wr_data0;
                w_rd_busy[i]                  = 1'b0;
            end else begin
                w_rd_data[i*DATA_W +: DATA_W] = r_mem[v_addr];
                w_rd_busy[i]                  = r_busy[v_addr];
            end
        end
    end

    assign rd_data    = w_rd_data;
    assign rd_busy    = w_rd_busy;
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    logic        clk;
    logic        rstd;
    logic [9:0]  rd_addr;
    logic        wr_en0;
    logic [4:0]  wr_addr0;
    logic [31:0] wr_data0;
    logic        wr_en1;
    logic [4:0]  wr_addr1;
    logic [31:0] wr_data1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  busy_count_a, busy_count_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: index 0 = (BYPASS=1, ZERO_REG=1), index 1 = (BYPASS=0, ZERO_REG=0)
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rstd(rstd), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count_a));

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .rstd(rstd), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            bit zr, bp;
            int cnt;
            zr = (c == 0);
            bp = (c == 0);
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] ed, od;
                logic        eb, ob, hit0, hit1;
                a    = rd_addr[p*5 +: 5];
                hit1 = wr_en1 && !(zr && wr_addr1 == 5'd0) && (wr_addr1 == a);
                hit0 = wr_en0 && !(zr && wr_addr0 == 5'd0) && (wr_addr0 == a);
                ed   = m_mem[c][a];
                eb   = m_busy[c][a];
                if (zr && a == 5'd0)  begin ed = 32'd0;    eb = 1'b0; end
                else if (bp && hit1)  begin ed = wr_data1; eb = 1'b0; end
                else if (bp && hit0)  begin ed = wr_data0; eb = 1'b0; end
                od = (c == 0) ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32];
                ob = (c == 0) ? rd_busy_a[p] : rd_busy_b[p];
                chk($sformatf("rd_data cfg%0d port%0d addr%0d", c, p, a), od, ed);
                chk($sformatf("rd_busy cfg%0d port%0d addr%0d", c, p, a), {31'd0, ob}, {31'd0, eb});
            end
            cnt = 0;
            for (int r = 0; r < 32; r++) cnt += int'(m_busy[c][r]);
            chk($sformatf("busy_count cfg%0d", c),
                (c == 0) ? {26'd0, busy_count_a} : {26'd0, busy_count_b}, 32'(cnt));
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            bit zr;
            zr = (c == 0);
            if (!rstd) begin
                for (int r = 0; r < 32; r++) begin
                    m_mem[c][r]  = 32'd0;
                    m_busy[c][r] = 1'b0;
                end
            end else begin
                if (wr_en0 && !(zr && wr_addr0 == 5'd0)) begin
                    m_mem[c][wr_addr0]  = wr_data0;
                    m_busy[c][wr_addr0] = 1'b0;
                end
                if (wr_en1 && !(zr && wr_addr1 == 5'd0)) begin
                    m_mem[c][wr_addr1]  = wr_data1;
                    m_busy[c][wr_addr1] = 1'b0;
                end
                if (rsv_en && !(zr && rsv_addr == 5'd0)) m_busy[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    // Inputs are set just after a negedge; check, take the posedge, advance the model.
    task automatic cycle();
        #1;
        if (rstd) check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        rstd = 1'b1; wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0;
        wr_addr0 = 5'd0; wr_addr1 = 5'd0; rsv_addr = 5'd0;
        wr_data0 = 32'd0; wr_data1 = 32'd0;
        rd_addr = {ra1, ra0};
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin m_mem[c][r] = 32'd0; m_busy[c][r] = 1'b0; end
        idle(5'd0, 5'd0);
        rstd = 1'b0;
        @(negedge clk);
        cycle();

        // 1: reset clears written data
        idle(5'd5, 5'd5); wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF; cycle();
        idle(5'd5, 5'd5); rstd = 1'b0; cycle();
        idle(5'd5, 5'd1); #1;
        chk("reset_r5_data", rd_data_a[31:0], 32'd0);
        chk("reset_busy_count", {26'd0, busy_count_a}, 32'd0);
        cycle();

        // 2: write priority on the same address
        idle(5'd1, 5'd7);
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11111111;
        wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22222222;
        #1; chk("prio_bypass_same_cycle", rd_data_a[63:32], 32'h22222222);
        cycle();
        idle(5'd7, 5'd7); #1;
        chk("prio_next_cycle_a", rd_data_a[31:0], 32'h22222222);
        chk("prio_next_cycle_b", rd_data_b[31:0], 32'h22222222);
        cycle();

        // 3: zero register ignores write and reserve
        idle(5'd0, 5'd7); wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; cycle();
        idle(5'd0, 5'd0); #1;
        chk("zero_reg_data", rd_data_a[31:0], 32'd0);
        chk("zero_reg_busy", {31'd0, rd_busy_a[0]}, 32'd0);
        chk("zero_reg_count", {26'd0, busy_count_a}, 32'd0);
        cycle();

        // 4: bypass versus stored-only read
        idle(5'd3, 5'd3); wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'h00000123; cycle();
        idle(5'd0, 5'd3); wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h00000ABC;
        #1;
        chk("bypass_on", rd_data_a[63:32], 32'h00000ABC);
        chk("bypass_off_old", rd_data_b[63:32], 32'h00000123);
        cycle();
        idle(5'd0, 5'd3); #1; chk("bypass_off_next", rd_data_b[63:32], 32'h00000ABC); cycle();

        // 5: scoreboard
        idle(5'd4, 5'd9); rsv_en = 1'b1; rsv_addr = 5'd4; cycle();
        idle(5'd4, 5'd9); rsv_en = 1'b1; rsv_addr = 5'd9; cycle();
        idle(5'd4, 5'd9); #1; chk("sb_two_reserved", {26'd0, busy_count_a}, 32'd2); cycle();
        idle(5'd4, 5'd9); wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44;
        rsv_en = 1'b1; rsv_addr = 5'd4; cycle();
        idle(5'd4, 5'd9); #1;
        chk("sb_write_and_reserve_count", {26'd0, busy_count_a}, 32'd2);
        chk("sb_r4_still_busy", {31'd0, rd_busy_a[0]}, 32'd1);
        cycle();
        idle(5'd4, 5'd9); wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h99; cycle();
        idle(5'd4, 5'd9); #1; chk("sb_after_wb_r9", {26'd0, busy_count_a}, 32'd1); cycle();

        // 6: reset in the middle of operation
        for (int r = 1; r <= 3; r++) begin
            idle(5'd1, 5'd2); rsv_en = 1'b1; rsv_addr = 5'(r); cycle();
        end
        idle(5'd2, 5'd1); rstd = 1'b0; wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'h5; cycle();
        idle(5'd2, 5'd3); #1;
        chk("midrst_count", {26'd0, busy_count_a}, 32'd0);
        chk("midrst_r2", rd_data_a[31:0], 32'd0);
        chk("midrst_busy", {30'd0, rd_busy_a}, 32'd0);
        cycle();

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 1) == 1);
            rstd     = ($urandom_range(0, 79) != 0);
            wr_en0   = $urandom_range(0, 1) == 1;
            wr_en1   = $urandom_range(0, 2) == 0;
            rsv_en   = $urandom_range(0, 1) == 1;
            wr_addr0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_addr1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rsv_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            rd_addr  = narrow ? {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))} : 10'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
